// File: rtl/stage4_memwb.sv
// stage4_memwb: stage-3 result sink doing an optional mem load/store, then a 1-cycle regfile writeback; ALU op 2 cycles,
// mem op 2+k cycles (k = ack delay). InReady low outside IDLE stalls stage 3. Forwarding outputs need STAGE4_FWD_EN.
module stage4_memwb #(
   parameter int MEM_TIMEOUT = 15,
   parameter int DATA_W      = 16
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              InValid,
   output logic              InReady,
   input  logic [DATA_W-1:0] ResIn,
   input  logic [DATA_W-1:0] StoreData,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic              RegWrite,
   input  logic [3:0]        DestReg,
   output logic              MemReq,
   output logic              MemWE,
   output logic [DATA_W-1:0] MemAddr,
   output logic [DATA_W-1:0] MemWData,
   input  logic [DATA_W-1:0] MemRData,
   input  logic              MemAck,
   output logic              WBEn,
   output logic [3:0]        WBReg,
   output logic [DATA_W-1:0] WBData,
   output logic              MemErr,
   output logic              FwdValid,
   output logic [3:0]        FwdReg,
   output logic [DATA_W-1:0] FwdData
);

   typedef enum logic [1:0] {IDLE, REQ, WB} state_t;

   // The access aborts on the REQ cycle whose increment brings the count to MEM_TIMEOUT.
   localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

   state_t            state, state_nxt;
   logic [DATA_W-1:0] addr_q, wdata_q, rdata_q;
   logic              rd_q, wr_q, rw_q, abort_q, err_q;
   logic [3:0]        dest_q;
   logic [7:0]        cnt_q;
   logic              expired;

   assign expired = (cnt_q >= TIMEOUT_LAST);

   always_ff @(posedge CLK) begin
      if (RST) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      InReady   = 1'b0;
      MemReq    = 1'b0;
      MemWE     = 1'b0;
      MemAddr   = '0;
      MemWData  = '0;
      WBEn      = 1'b0;
      WBReg     = '0;
      WBData    = '0;
      case (state)
         IDLE: begin
            InReady = 1'b1;
            if (InValid) state_nxt = (MemRead || MemWrite) ? REQ : WB;
         end
         REQ: begin
            MemReq   = 1'b1;
            MemWE    = wr_q && !rd_q;
            MemAddr  = addr_q;
            MemWData = wdata_q;
            if (MemAck || expired) state_nxt = WB;
         end
         WB: begin
            WBEn      = rw_q && (dest_q != 4'd0) && !abort_q;
            WBReg     = dest_q;
            WBData    = rd_q ? rdata_q : addr_q;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         rw_q    <= 1'b0;
         dest_q  <= '0;
         cnt_q   <= '0;
         abort_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (InValid) begin
                  addr_q  <= ResIn;
                  wdata_q <= StoreData;
                  rd_q    <= MemRead;
                  wr_q    <= MemWrite;
                  rw_q    <= RegWrite;
                  dest_q  <= DestReg;
                  cnt_q   <= '0;
                  abort_q <= 1'b0;
               end
            end
            REQ: begin
               if (MemAck) begin
                  if (rd_q) rdata_q <= MemRData;
               end else begin
                  if (cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
                  if (expired) begin
                     err_q   <= 1'b1;
                     abort_q <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign MemErr = err_q;

`ifdef STAGE4_FWD_EN
   assign FwdValid = WBEn;
   assign FwdReg   = WBEn ? WBReg  : '0;
   assign FwdData  = WBEn ? WBData : '0;
`else
   assign FwdValid = 1'b0;
   assign FwdReg   = '0;
   assign FwdData  = '0;
`endif

endmodule

// File: doc/stage4_memwb.md
Name: stage4_memwb

Overview:
- Consumer end of the stage-3 result path: accepts the registered ALU result (ResOut) plus control from stage 3 via a valid/ready handshake.
- Performs an optional 16-bit memory load/store over a request/acknowledge bus.
- Issues a single-cycle register-file writeback.
- Multi-cycle stage sitting between stage 3 and the register file; stalls stage 3 via InReady while a memory access is outstanding.

Parameters:
- MEM_TIMEOUT, 15, number of REQ-state cycles without MemAck before the access is aborted (1..255).
- DATA_W, 16, datapath width; all data/address ports use this width.

Ports:
- CLK  in  1  rising-edge clock
- RST  in  1  synchronous active-high reset
- InValid  in  1  stage 3 presents a valid result this cycle
- InReady  out  1  stage 4 can accept; transfer occurs when InValid&&InReady at a CLK edge
- ResIn  in  16  stage-3 result; used as memory address or writeback data
- StoreData  in  16  data for stores
- MemRead  in  1  op is a load
- MemWrite  in  1  op is a store
- RegWrite  in  1  op writes the register file
- DestReg  in  4  destination register index
- MemReq  out  1  memory request, held until acknowledged
- MemWE  out  1  1=store, 0=load; valid while MemReq=1
- MemAddr  out  16  captured ResIn; valid while MemReq=1
- MemWData  out  16  captured StoreData; valid while MemReq=1
- MemRData  in  16  load data; sampled on the cycle MemAck=1
- MemAck  in  1  memory completes the access this cycle
- WBEn  out  1  register write strobe, 1 cycle
- WBReg  out  4  register index for writeback
- WBData  out  16  writeback value
- MemErr  out  1  sticky timeout flag; cleared only by RST
- FwdValid  out  1  forwarding valid (see Optional Feature)
- FwdReg  out  4  forwarding register index
- FwdData  out  16  forwarding value

Behaviour:
- States: IDLE, REQ, WB. Registered state; all outputs decode from registered state/capture registers, never combinationally from inputs.
- Reset (RST=1 at an edge): state=IDLE. Capture registers, timeout counter, MemErr and all outputs go to 0, except InReady=1. Reset mid-REQ drops MemReq on the next cycle; the op is lost.
- IDLE:
  - InReady=1.
  - On InValid=1, capture ResIn, StoreData, MemRead, MemWrite, RegWrite, DestReg and clear the counter.
  - If MemRead|MemWrite, go to REQ; else go to WB.
  - With InValid=0, stay in IDLE.
- REQ:
  - InReady=0, MemReq=1, MemWE=captured MemWrite&&!MemRead (read wins if both set).
  - When MemAck=1 at an edge: latch MemRData if load, go to WB.
  - Otherwise increment the counter. If the counter reaches MEM_TIMEOUT without ack: set MemErr, mark the op aborted, go to WB.
- WB:
  - InReady=0; exactly one cycle, then IDLE.
  - WBEn = captured RegWrite && DestReg!=0 && !aborted.
  - WBData = loaded data if load, else captured ResIn. Stores with RegWrite=1 write back ResIn.
- Latency/throughput:
  - Non-memory op: captured at edge N, WBEn high during cycle N+1, InReady high again cycle N+2; 2 cycles per op.
  - Memory op acked k cycles after MemReq rises (k≥0 meaning ack in the first REQ cycle): WB in cycle N+2+k.
- MemAck while not in REQ is ignored.
- MemReq, MemAddr, MemWData, MemWE are stable for the entire REQ state.
- Counter saturates and never wraps.

Optional Feature:
- Macro STAGE4_FWD_EN.
- Defined: during WB with WBEn=1, FwdValid=1, FwdReg=WBReg, FwdData=WBData, so stage 2 can bypass the register file for the in-flight value.
- Undefined: FwdValid, FwdReg and FwdData are tied to 0; ports remain present so instantiation is identical.

Test Plan:
- ALU op: ResIn=16'h1234, RegWrite=1, DestReg=3, InValid pulsed at edge N → WBEn=1, WBReg=3, WBData=1234 in cycle N+1 only; InReady=0 at N+1, 1 at N+2; MemReq never asserts.
- Load: ResIn=16'h0040, MemRead=1, RegWrite=1, DestReg=5; MemAck after 3 REQ cycles with MemRData=16'hBEEF → MemReq=1 with MemAddr=0040, MemWE=0 for 4 cycles; WBData=BEEF, WBEn=1 for one cycle.
- Store: ResIn=16'h0010, StoreData=16'hA5A5, MemWrite=1, RegWrite=0; immediate ack → MemWE=1, MemWData=A5A5 for 1 cycle; WBEn stays 0.
- Timeout: MemRead=1, MemAck held 0 → MemReq high for exactly 15 cycles; MemErr=1 thereafter; WBEn=0; InReady returns to 1; MemErr persists until RST.
- Edge cases: DestReg=0 with RegWrite=1 → WBEn=0. RST asserted during REQ → next cycle MemReq=0, InReady=1, all outputs 0. Back-to-back InValid for 10 ALU ops → one writeback every 2 cycles, values in order.
- With STAGE4_FWD_EN: the first ALU-op scenario also shows FwdValid=1, FwdReg=3, FwdData=1234 in the WB cycle. Without it, the Fwd* outputs stay 0 throughout.
